// File: rtl/bellek_asamasi_pkg.sv
// rtl/bellek_asamasi_pkg.sv - shared types and helpers for the memory stage
//
// Purpose: uop layout, memory-op encodings, FSM state encodings and
//          small decode helpers used by bellek_asamasi and bellek_hizalayici.
// Ports:   none (package).

package bellek_asamasi_pkg;

   localparam int VERI_W = 32;

   typedef enum logic [3:0] {
      BELLEK_YOK = 4'd0,
      BELLEK_LB  = 4'd1,
      BELLEK_LH  = 4'd2,
      BELLEK_LW  = 4'd3,
      BELLEK_LBU = 4'd4,
      BELLEK_LHU = 4'd5,
      BELLEK_SB  = 4'd6,
      BELLEK_SH  = 4'd7,
      BELLEK_SW  = 4'd8
   } bellek_op_t;

   typedef enum logic [1:0] {
      BELLEK_BOSTA = 2'd0,
      BELLEK_ISTEK = 2'd1,
      BELLEK_YANIT = 2'd2
   } durum_t;

   // rd carries the computed address for memory ops and the result otherwise.
   typedef struct packed {
      logic              valid;
      logic [3:0]        tag;
      logic [4:0]        rd_addr;
      logic              rd_alloc;
      bellek_op_t        bellek;
      logic [VERI_W-1:0] rs2;
      logic [VERI_W-1:0] rd;
   } uop_t;

   function automatic logic bellek_mi(input bellek_op_t op);
      return op inside {BELLEK_LB, BELLEK_LH, BELLEK_LW, BELLEK_LBU, BELLEK_LHU,
                        BELLEK_SB, BELLEK_SH, BELLEK_SW};
   endfunction

   function automatic logic yazma_mi(input bellek_op_t op);
      return op inside {BELLEK_SB, BELLEK_SH, BELLEK_SW};
   endfunction

   // Byte accesses are always aligned; halves need bit 0 clear, words both bits.
   function automatic logic hizali_mi(input bellek_op_t op, input logic [1:0] ofs);
      logic sonuc;
      case (op)
         BELLEK_LH, BELLEK_LHU, BELLEK_SH: sonuc = ~ofs[0];
         BELLEK_LW, BELLEK_SW:             sonuc = (ofs == 2'b00);
         default:                          sonuc = 1'b1;
      endcase
      return sonuc;
   endfunction

endpackage

// File: rtl/bellek_asamasi_hizalayici.sv
// rtl/bellek_asamasi_hizalayici.sv - combinational load extract/extend and store lane shift/mask
//
// Purpose: module bellek_hizalayici; turns a raw load word into the
//          aligned, extended result and a store operand into lane data + byte mask.
// Ports:   op_i        memory op of the latched uop
//          ofs_i       byte offset addr[1:0]
//          st_veri_i   store data (uop rs2)
//          yuk_veri_i  raw load word from memory
//          st_veri_o   lane-replicated store data
//          st_maske_o  byte enables (all ones for loads and word stores)
//          yuk_veri_o  aligned, sign/zero-extended load result

module bellek_hizalayici
   import bellek_asamasi_pkg::*;
(
   input  bellek_op_t          op_i,
   input  logic [1:0]          ofs_i,
   input  logic [VERI_W-1:0]   st_veri_i,
   input  logic [VERI_W-1:0]   yuk_veri_i,
   output logic [VERI_W-1:0]   st_veri_o,
   output logic [VERI_W/8-1:0] st_maske_o,
   output logic [VERI_W-1:0]   yuk_veri_o
);

   logic [7:0]  bayt;
   logic [15:0] yarim;

   always_comb begin
      bayt  = yuk_veri_i[{ofs_i, 3'b000} +: 8];
      // Halves are only ever taken from an aligned lane, so bit 0 is not needed.
      yarim = yuk_veri_i[{ofs_i[1], 4'b0000} +: 16];

      case (op_i)
         BELLEK_LB:  yuk_veri_o = {{24{bayt[7]}}, bayt};
         BELLEK_LBU: yuk_veri_o = {24'h0, bayt};
         BELLEK_LH:  yuk_veri_o = {{16{yarim[15]}}, yarim};
         BELLEK_LHU: yuk_veri_o = {16'h0, yarim};
         default:    yuk_veri_o = yuk_veri_i;
      endcase

      case (op_i)
         BELLEK_SB: begin
            st_veri_o  = {4{st_veri_i[7:0]}};
            st_maske_o = 4'b0001 << ofs_i;
         end
         BELLEK_SH: begin
            st_veri_o  = {2{st_veri_i[15:0]}};
            st_maske_o = 4'b0011 << ofs_i;
         end
         default: begin
            st_veri_o  = st_veri_i;
            st_maske_o = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/bellek_asamasi.sv
// rtl/bellek_asamasi.sv - memory stage between execute and writeback
//
// Purpose: passes non-memory uops through with one cycle of latency, runs
//          loads/stores on a single-outstanding valid/ready memory port and
//          stalls execute while an access is in flight.
// Ports:   clk_i, rstn_i (sync, active-low)
//          yurut_uop_i / duraklat_o          uop from execute, stall back
//          gy_uop_o                          registered uop to writeback
//          bellek_istek_*                    memory request channel
//          bellek_yanit_*                    memory response channel
//          yanlis_hiza_o                     one-cycle misaligned-drop pulse

module bellek_asamasi
   import bellek_asamasi_pkg::*;
#(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  uop_t                  yurut_uop_i,
   output logic                  duraklat_o,
   output uop_t                  gy_uop_o,
   output logic                  bellek_istek_gecerli_o,
   input  logic                  bellek_istek_hazir_i,
   output logic [ADRES_BIT-1:0]  bellek_istek_adres_o,
   output logic [VERI_BIT-1:0]   bellek_istek_veri_o,
   output logic [VERI_BIT/8-1:0] bellek_istek_maske_o,
   output logic                  bellek_istek_yaz_o,
   input  logic                  bellek_yanit_gecerli_i,
   input  logic [VERI_BIT-1:0]   bellek_yanit_veri_i,
   output logic                  bellek_yanit_hazir_o,
   output logic                  yanlis_hiza_o
);

   durum_t durum_q, durum_d;
   uop_t   uop_q, uop_d;
   uop_t   gy_q, gy_d;
   logic   hiza_q, hiza_d;

   logic [VERI_W-1:0]   st_veri;
   logic [VERI_W/8-1:0] st_maske;
   logic [VERI_W-1:0]   yuk_veri;

   // Both the request and the response path work off the latched uop, so a
   // single aligner instance serves them.
   bellek_hizalayici u_hizalayici (
      .op_i       (uop_q.bellek),
      .ofs_i      (uop_q.rd[1:0]),
      .st_veri_i  (uop_q.rs2),
      .yuk_veri_i (bellek_yanit_veri_i),
      .st_veri_o  (st_veri),
      .st_maske_o (st_maske),
      .yuk_veri_o (yuk_veri)
   );

   always_comb begin
      durum_d = durum_q;
      uop_d   = uop_q;
      gy_d    = '0;
      hiza_d  = 1'b0;

      case (durum_q)
         BELLEK_BOSTA: begin
            if (yurut_uop_i.valid) begin
               if (!bellek_mi(yurut_uop_i.bellek)) begin
                  gy_d = yurut_uop_i;
               end else if (hizali_mi(yurut_uop_i.bellek, yurut_uop_i.rd[1:0])) begin
                  uop_d   = yurut_uop_i;
                  durum_d = BELLEK_ISTEK;
               end else begin
                  gy_d          = yurut_uop_i;
                  gy_d.rd_alloc = 1'b0;
                  hiza_d        = 1'b1;
               end
            end
         end
         BELLEK_ISTEK: begin
            if (bellek_istek_hazir_i) begin
               if (yazma_mi(uop_q.bellek)) begin
                  gy_d          = uop_q;
                  gy_d.rd_alloc = 1'b0;
                  durum_d       = BELLEK_BOSTA;
               end else begin
                  durum_d = BELLEK_YANIT;
               end
            end
         end
         BELLEK_YANIT: begin
            if (bellek_yanit_gecerli_i) begin
               gy_d    = uop_q;
               gy_d.rd = yuk_veri;
               durum_d = BELLEK_BOSTA;
            end
         end
         default: durum_d = BELLEK_BOSTA;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         durum_q <= BELLEK_BOSTA;
         uop_q   <= '0;
         gy_q    <= '0;
         hiza_q  <= 1'b0;
      end else begin
         durum_q <= durum_d;
         uop_q   <= uop_d;
         gy_q    <= gy_d;
         hiza_q  <= hiza_d;
      end
   end

   assign duraklat_o             = (durum_q != BELLEK_BOSTA);
   assign gy_uop_o               = gy_q;
   assign yanlis_hiza_o          = hiza_q;
   assign bellek_istek_gecerli_o = (durum_q == BELLEK_ISTEK);
   assign bellek_istek_adres_o   = {uop_q.rd[ADRES_BIT-1:2], 2'b00};
   assign bellek_istek_veri_o    = st_veri;
   assign bellek_istek_maske_o   = st_maske;
   assign bellek_istek_yaz_o     = yazma_mi(uop_q.bellek);
   // Idle also accepts responses so anything left over from a reset mid-load drains.
   assign bellek_yanit_hazir_o   = (durum_q != BELLEK_ISTEK);

endmodule

// File: tb/tb_bellek_asamasi.sv
// tb/tb_bellek_asamasi.sv - self-checking bench for bellek_asamasi

module tb_bellek_asamasi;
   import bellek_asamasi_pkg::*;

   logic        clk;
   logic        rstn;
   uop_t        yurut_uop;
   logic        duraklat;
   uop_t        gy_uop;
   logic        istek_gecerli;
   logic        istek_hazir;
   logic [31:0] istek_adres;
   logic [31:0] istek_veri;
   logic [3:0]  istek_maske;
   logic        istek_yaz;
   logic        yanit_gecerli;
   logic [31:0] yanit_veri;
   logic        yanit_hazir;
   logic        yanlis_hiza;

   bellek_asamasi #(.ADRES_BIT(32), .VERI_BIT(32)) dut (
      .clk_i                  (clk),
      .rstn_i                 (rstn),
      .yurut_uop_i            (yurut_uop),
      .duraklat_o             (duraklat),
      .gy_uop_o               (gy_uop),
      .bellek_istek_gecerli_o (istek_gecerli),
      .bellek_istek_hazir_i   (istek_hazir),
      .bellek_istek_adres_o   (istek_adres),
      .bellek_istek_veri_o    (istek_veri),
      .bellek_istek_maske_o   (istek_maske),
      .bellek_istek_yaz_o     (istek_yaz),
      .bellek_yanit_gecerli_i (yanit_gecerli),
      .bellek_yanit_veri_i    (yanit_veri),
      .bellek_yanit_hazir_o   (yanit_hazir),
      .yanlis_hiza_o          (yanlis_hiza)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      bellek_op_t  op;
      logic [31:0] adr;
      logic [31:0] rs2;
      logic [31:0] yanit;
      logic [3:0]  gecikme;
      logic [31:0] exp_rd;
      logic        exp_alloc;
      logic        exp_hiza;
      logic        exp_istek;
      logic [31:0] exp_adres;
      logic [31:0] exp_veri;
      logic [3:0]  exp_maske;
      logic        exp_yaz;
   } vec_t;

   typedef struct packed {
      uop_t u;
      logic hiza;
   } cikis_t;

   int     checks = 0;
   int     errors = 0;
   cikis_t beklenen_q[$];
   cikis_t mon_e;
   vec_t   tablo[14];

   task automatic chk(input string ad, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", ad, act, exp);
      end
   endtask

   function automatic vec_t mk(input bellek_op_t op, input logic [31:0] adr, input logic [31:0] rs2,
                               input logic [31:0] yanit, input logic [3:0] gec, input logic [31:0] exp_rd,
                               input logic alloc, input logic hiza, input logic istek,
                               input logic [31:0] eadr, input logic [31:0] everi,
                               input logic [3:0] emask, input logic eyaz);
      vec_t v;
      v.op = op; v.adr = adr; v.rs2 = rs2; v.yanit = yanit; v.gecikme = gec;
      v.exp_rd = exp_rd; v.exp_alloc = alloc; v.exp_hiza = hiza; v.exp_istek = istek;
      v.exp_adres = eadr; v.exp_veri = everi; v.exp_maske = emask; v.exp_yaz = eyaz;
      return v;
   endfunction

   // Scoreboard: every valid writeback uop must match the oldest expectation.
   always @(negedge clk) begin
      if (gy_uop.valid === 1'b1) begin
         if (beklenen_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gy act=%0h exp=none", gy_uop);
         end else begin
            mon_e = beklenen_q.pop_front();
            chk("gy_uop", 96'(gy_uop), 96'(mon_e.u));
            chk("yanlis_hiza", 96'(yanlis_hiza), 96'(mon_e.hiza));
         end
      end else if (yanlis_hiza === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL stray_hiza act=1 exp=0");
      end
   end

   task automatic bekle_bos();
      int n;
      n = 0;
      while (beklenen_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("gy_timeout", 96'(beklenen_q.size()), 96'(0));
      beklenen_q.delete();
   endtask

   task automatic bekle_serbest();
      int n;
      n = 0;
      while (duraklat && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_timeout", 96'(duraklat), 96'(0));
   endtask

   function automatic uop_t yap_uop(input bellek_op_t op, input logic [31:0] adr, input logic [31:0] rs2,
                                    input logic [3:0] tag, input logic [4:0] rda);
      uop_t u;
      u = '0;
      u.valid = 1'b1; u.tag = tag; u.rd_addr = rda; u.rd_alloc = 1'b1;
      u.bellek = op; u.rs2 = rs2; u.rd = adr;
      return u;
   endfunction

   task automatic calistir(input vec_t v, input logic [3:0] tag, input logic [4:0] rda);
      uop_t   u;
      cikis_t e;
      bekle_serbest();
      u = yap_uop(v.op, v.adr, v.rs2, tag, rda);
      e.u = u; e.u.rd = v.exp_rd; e.u.rd_alloc = v.exp_alloc; e.hiza = v.exp_hiza;
      beklenen_q.push_back(e);
      yurut_uop = u;
      @(negedge clk);
      yurut_uop = '0;
      chk("istek_gecerli", 96'(istek_gecerli), 96'(v.exp_istek));
      if (v.exp_istek) begin
         for (int d = 0; d <= int'(v.gecikme); d++) begin
            chk("istek_gecerli_held", 96'(istek_gecerli), 96'(1));
            chk("istek_adres", 96'(istek_adres), 96'(v.exp_adres));
            chk("istek_maske", 96'(istek_maske), 96'(v.exp_maske));
            chk("istek_yaz", 96'(istek_yaz), 96'(v.exp_yaz));
            if (v.exp_yaz) chk("istek_veri", 96'(istek_veri), 96'(v.exp_veri));
            if (d == int'(v.gecikme)) istek_hazir = 1'b1;
            @(negedge clk);
         end
         istek_hazir = 1'b0;
         if (!v.exp_yaz) begin
            chk("yanit_hazir", 96'(yanit_hazir), 96'(1));
            chk("istek_dropped", 96'(istek_gecerli), 96'(0));
            yanit_gecerli = 1'b1;
            yanit_veri    = v.yanit;
            @(negedge clk);
            yanit_gecerli = 1'b0;
            yanit_veri    = '0;
         end
      end else begin
         chk("duraklat_idle", 96'(duraklat), 96'(0));
      end
      bekle_bos();
   endtask

   initial begin
      uop_t   u;
      cikis_t e;
      #100000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   initial begin
      uop_t   u;
      cikis_t e;

      tablo[0]  = mk(BELLEK_YOK, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'd0, 32'hDEAD_BEEF, 1, 0, 0, 32'h0, 32'h0, 4'h0, 0);
      tablo[1]  = mk(BELLEK_LW,  32'h100, 32'h0, 32'h1234_5678, 4'd3, 32'h1234_5678, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);
      tablo[2]  = mk(BELLEK_LB,  32'h103, 32'h0, 32'h8000_0000, 4'd0, 32'hFFFF_FF80, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);
      tablo[3]  = mk(BELLEK_LBU, 32'h103, 32'h0, 32'h8000_0000, 4'd1, 32'h0000_0080, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);
      tablo[4]  = mk(BELLEK_LHU, 32'h102, 32'h0, 32'hBEEF_0000, 4'd0, 32'h0000_BEEF, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);
      tablo[5]  = mk(BELLEK_LH,  32'h102, 32'h0, 32'hBEEF_0000, 4'd2, 32'hFFFF_BEEF, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);
      tablo[6]  = mk(BELLEK_SH,  32'h202, 32'h0000_ABCD, 32'h0, 4'd1, 32'h202, 0, 0, 1, 32'h200, 32'hABCD_ABCD, 4'b1100, 1);
      tablo[7]  = mk(BELLEK_SB,  32'h301, 32'h0000_005A, 32'h0, 4'd0, 32'h301, 0, 0, 1, 32'h300, 32'h5A5A_5A5A, 4'b0010, 1);
      tablo[8]  = mk(BELLEK_SW,  32'h400, 32'h1122_3344, 32'h0, 4'd2, 32'h400, 0, 0, 1, 32'h400, 32'h1122_3344, 4'b1111, 1);
      tablo[9]  = mk(BELLEK_LW,  32'h101, 32'h0, 32'h0, 4'd0, 32'h101, 0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
      tablo[10] = mk(BELLEK_LH,  32'h103, 32'h0, 32'h0, 4'd0, 32'h103, 0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
      tablo[11] = mk(BELLEK_SH,  32'h201, 32'h1234, 32'h0, 4'd0, 32'h201, 0, 1, 0, 32'h0, 32'h0, 4'h0, 0);
      tablo[12] = mk(BELLEK_LB,  32'h100, 32'h0, 32'h0000_007F, 4'd0, 32'h0000_007F, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);
      tablo[13] = mk(BELLEK_LHU, 32'h100, 32'h0, 32'h1234_ABCD, 4'd1, 32'h0000_ABCD, 1, 0, 1, 32'h100, 32'h0, 4'hF, 0);

      rstn          = 1'b0;
      yurut_uop     = '0;
      istek_hazir   = 1'b0;
      yanit_gecerli = 1'b0;
      yanit_veri    = '0;
      repeat (3) @(negedge clk);
      chk("reset_gy", 96'(gy_uop), 96'(0));
      chk("reset_istek", 96'(istek_gecerli), 96'(0));
      chk("reset_hiza", 96'(yanlis_hiza), 96'(0));
      chk("reset_duraklat", 96'(duraklat), 96'(0));
      rstn = 1'b1;
      @(negedge clk);

      tablo[0].exp_rd = 32'hDEAD_BEEF;
      calistir(tablo[0], 4'd5, 5'd1);
      for (int i = 1; i < 14; i++) calistir(tablo[i], 4'(i), 5'(i + 2));

      // Response offered while the request is still pending must be ignored.
      bekle_serbest();
      u = yap_uop(BELLEK_LW, 32'h600, 32'h0, 4'd3, 5'd7);
      e.u = u; e.u.rd = 32'h0A0B_0C0D; e.hiza = 1'b0;
      beklenen_q.push_back(e);
      yurut_uop = u;
      @(negedge clk);
      yurut_uop = '0;
      chk("istek_yanit_hazir", 96'(yanit_hazir), 96'(0));
      yanit_gecerli = 1'b1;
      yanit_veri    = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("istek_still_pending", 96'(istek_gecerli), 96'(1));
      yanit_gecerli = 1'b0;
      istek_hazir   = 1'b1;
      @(negedge clk);
      istek_hazir   = 1'b0;
      yanit_gecerli = 1'b1;
      yanit_veri    = 32'h0A0B_0C0D;
      @(negedge clk);
      yanit_gecerli = 1'b0;
      bekle_bos();

      // Reset while waiting for the response: the late response is drained, nothing emitted.
      bekle_serbest();
      yurut_uop   = yap_uop(BELLEK_LW, 32'h500, 32'h0, 4'd9, 5'd9);
      istek_hazir = 1'b1;
      @(negedge clk);
      yurut_uop = '0;
      @(negedge clk);
      istek_hazir = 1'b0;
      chk("yanit_state_stall", 96'(duraklat), 96'(1));
      chk("yanit_state_hazir", 96'(yanit_hazir), 96'(1));
      rstn = 1'b0;
      @(negedge clk);
      chk("rst_yanit_duraklat", 96'(duraklat), 96'(0));
      chk("rst_yanit_istek", 96'(istek_gecerli), 96'(0));
      rstn          = 1'b1;
      yanit_gecerli = 1'b1;
      yanit_veri    = 32'hCAFE_F00D;
      @(negedge clk);
      yanit_gecerli = 1'b0;
      chk("drain_gy_valid", 96'(gy_uop.valid), 96'(0));
      chk("drain_duraklat", 96'(duraklat), 96'(0));
      @(negedge clk);
      chk("drain_gy_valid2", 96'(gy_uop.valid), 96'(0));

      // Reset while the request is pending withdraws it.
      yurut_uop = yap_uop(BELLEK_SW, 32'h700, 32'h5555_AAAA, 4'd10, 5'd10);
      @(negedge clk);
      yurut_uop = '0;
      chk("istek_before_rst", 96'(istek_gecerli), 96'(1));
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("istek_withdrawn", 96'(istek_gecerli), 96'(0));
      @(negedge clk);
      chk("istek_rst_gy", 96'(gy_uop.valid), 96'(0));

      calistir(tablo[1], 4'd15, 5'd31);
      calistir(tablo[6], 4'd14, 5'd30);

      chk("queue_empty", 96'(beklenen_q.size()), 96'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
